sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, number of low SRAM_ADDR bits decoded (array depth 2^ADDR_BITS words of 16 bits).
REQ-002 SHALL have parameter READ_LAT, default 2, legal range 1..4, cycles from address sample to read data on SRAM_DQ.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SRAM_ADDR  input  18  word address from memory-stage controller.
REQ-006 SHALL have port SRAM_WE_N  input  1  write strobe, active-low; high = read.
REQ-007 SHALL have port SRAM_DQ  inout  16  bidirectional data bus.
REQ-008 SHALL have port rd_count  output  16  count of completed read beats.
REQ-009 SHALL have port wr_count  output  16  count of write beats.

Function
REQ-010 SHALL decode only SRAM_ADDR[ADDR_BITS-1:0]; higher bits ignored (addresses alias/wrap).
REQ-011 SHALL, on each rising edge with SRAM_WE_N=0, write SRAM_DQ into mem[addr]; one write beat per cycle held low.
REQ-012 SHALL keep SRAM_DQ high-Z in every cycle SRAM_WE_N=0.
REQ-013 SHALL, with SRAM_WE_N=1, sample address each cycle into a READ_LAT-deep address/valid pipeline; pipeline output drives SRAM_DQ with mem[sampled addr].
REQ-014 SHALL give read latency of exactly READ_LAT cycles: address stable at edge N -> data valid on SRAM_DQ after edge N+READ_LAT.
REQ-015 SHALL invalidate all pipeline entries when SRAM_WE_N=0; SRAM_DQ driven only when pipeline output entry valid AND SRAM_WE_N=1.
REQ-016 SHALL enforce one turnaround cycle: in the first cycle after SRAM_WE_N rises 0->1, SRAM_DQ stays high-Z regardless of pipeline state.
REQ-017 SHALL return newly written data for a read of an address written in any earlier cycle (read-after-write ordering, no stale data).
REQ-018 SHALL count one read beat per cycle the pipeline output is valid and driven; one write beat per cycle SRAM_WE_N=0 at the edge.
REQ-019 SHALL saturate both counters at 16'hFFFF (no wrap).
REQ-020 SHALL leave array contents unspecified at power-up and unchanged by reset.

Reset
REQ-021 SHALL, while rst=0, asynchronously clear address pipeline valids, turnaround flag, rd_count and wr_count to 0.
REQ-022 SHALL hold SRAM_DQ high-Z during reset and in the first cycle after rst deasserts.
REQ-023 SHALL block writes while rst=0 even if SRAM_WE_N=0; reset mid-read discards in-flight beats (no data driven).

Configuration
REQ-024 SHALL use macro SRAM_RESPONDER_STATS_EN: defined -> rd_count/wr_count counters implemented per REQ-018/019; undefined -> counters not built, ports tied to 16'h0000, read/write behaviour identical.

Verification
REQ-025 SHALL cover: WE_N=0, ADDR=18'h00010, DQ=16'hA5A5 one cycle, then WE_N=1 same addr -> DQ high-Z turnaround cycle, then 16'hA5A5 valid READ_LAT cycles after first read sample.
REQ-026 SHALL cover: write 16'h1234 to 18'h00003 then read 18'h10003 (ADDR_BITS=16) -> 16'h1234 (aliasing).
REQ-027 SHALL cover: back-to-back reads of addrs 0,1,2,3 preloaded 16'h0000..16'h0003 -> consecutive cycles show 0,1,2,3 after READ_LAT fill, one beat per cycle.
REQ-028 SHALL cover: rst pulled low with 2 reads in flight -> DQ high-Z immediately, rd_count=0, no beats after release until new reads complete READ_LAT later.
REQ-029 SHALL cover (STATS_EN): 70000 continuous write cycles -> wr_count=16'hFFFF, stays; without macro both counts read 16'h0000.
REQ-030 SHALL cover: read addr 5 (old 16'h0001), write 16'h0BEE to addr 5 next cycle, read again -> second read returns 16'h0BEE, first beat dropped (pipeline invalidated by write).

Source files
------------

// File: rtl/sram_responder.sv
// Behavioural async-SRAM responder: write-through on WE_N low, READ_LAT-cycle pipelined reads on SRAM_DQ.
// Define SRAM_RESPONDER_STATS_EN to build the saturating rd_count/wr_count beat counters.
module sram_responder #(
  parameter int ADDR_BITS = 16,
  parameter int READ_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_WE_N,
  inout  wire  [15:0] SRAM_DQ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef logic [ADDR_BITS-1:0] addr_t;

  logic [15:0]         mem [DEPTH];
  addr_t               addr;
  addr_t               addr_pipe [READ_LAT];
  logic [READ_LAT-1:0] valid_pipe;
  logic [15:0]         rd_data_q;
  logic                rd_valid_q;
  logic                wr_last_q;
  logic                dq_oe;

  // Upper address bits alias onto the decoded range.
  assign addr = SRAM_ADDR[ADDR_BITS-1:0];

  if (ADDR_BITS < 18) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^SRAM_ADDR[17:ADDR_BITS];
  end

  // The bus is released during any write cycle and for the first cycle after a write.
  assign dq_oe   = rd_valid_q & SRAM_WE_N & ~wr_last_q;
  assign SRAM_DQ = dq_oe ? rd_data_q : 'z;

  // Control state: valids, turnaround flag and the array write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: only control state is reset; mem is deliberately left untouched so reset
      // neither clears stored data nor lets a write slip through while rst is low.
      valid_pipe <= '0;
      rd_valid_q <= 1'b0;
      wr_last_q  <= 1'b0;
    end else begin
      if (!SRAM_WE_N) mem[addr] <= SRAM_DQ;
      wr_last_q     <= ~SRAM_WE_N;
      valid_pipe[0] <= SRAM_WE_N;
      for (int i = 1; i < READ_LAT; i++) valid_pipe[i] <= SRAM_WE_N & valid_pipe[i-1];
      rd_valid_q    <= SRAM_WE_N & valid_pipe[READ_LAT-1];
    end
  end

  // Datapath: address stages plus a synchronous array read form the READ_LAT-cycle latency.
  always_ff @(posedge clk) begin
    addr_pipe[0] <= addr;
    for (int i = 1; i < READ_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    rd_data_q <= mem[addr_pipe[READ_LAT-1]];
  end

`ifdef SRAM_RESPONDER_STATS_EN
  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;

  // A read beat is a cycle in which data was actually driven onto the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (dq_oe && rd_count_q != 16'hFFFF)      rd_count_q <= rd_count_q + 16'd1;
      if (!SRAM_WE_N && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: reads push expected beats, a negedge monitor pops and compares.
module tb_sram_responder;

  localparam int          ADDR_BITS = 16;
  localparam int          READ_LAT  = 2;
  localparam logic [15:0] RELEASED  = 16'hFFFF;
`ifdef SRAM_RESPONDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int N_WR = STATS ? 70000 : 16;

  typedef struct {
    int          due;
    bit          known;
    logic [15:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr;
  logic        we_n;
  logic [15:0] dq_drv;
  logic        tb_oe;
  wire  [15:0] SRAM_DQ;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          exp_rd = 0;
  int          exp_wr = 0;
  bit          mon_en = 1'b0;
  beat_t       sb [$];
  beat_t       mon_b;
  logic [15:0] model [int];

  always #5 clk = ~clk;

  assign SRAM_DQ = tb_oe ? dq_drv : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pull
    pullup (SRAM_DQ[i]);
  end

  sram_responder #(.ADDR_BITS(ADDR_BITS), .READ_LAT(READ_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .SRAM_ADDR (addr),
    .SRAM_WE_N (we_n),
    .SRAM_DQ   (SRAM_DQ),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  function automatic logic [15:0] want(int n);
    return STATS ? n[15:0] : 16'h0000;
  endfunction

  // Advance one clock, recording what the coming edge will do to the reference model.
  task automatic tick();
    beat_t b;
    int    k;
    k = int'(addr[ADDR_BITS-1:0]);
    if (rst) begin
      if (!we_n) begin
        model[k] = dq_drv;
        sb.delete();
        if (exp_wr < 65535) exp_wr++;
      end else begin
        b.due   = cyc + 1 + READ_LAT;
        b.known = (model.exists(k) != 0);
        b.data  = b.known ? model[k] : 16'h0000;
        sb.push_back(b);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_b = sb.pop_front();
        if (exp_rd < 65535) exp_rd++;
        if (mon_b.known) begin
          vectors++;
          if (SRAM_DQ !== mon_b.data) begin
            miscompares++;
            $display("FAIL rd_beat cyc=%0d: DQ=%h expected %h", cyc, SRAM_DQ, mon_b.data);
          end
        end
      end else if (!tb_oe) begin
        vectors++;
        if (SRAM_DQ !== RELEASED) begin
          miscompares++;
          $display("FAIL bus_idle cyc=%0d: DQ=%h expected released (%h)", cyc, SRAM_DQ, RELEASED);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; we_n = 1'b1; tb_oe = 1'b0; addr = '0; dq_drv = '0;
    repeat (3) tick();
    mon_en = 1'b1;
    vectors++;
    if (SRAM_DQ !== RELEASED) begin
      miscompares++; $display("FAIL reset_dq: DQ=%h expected released", SRAM_DQ);
    end
    vectors++;
    if (rd_count !== 16'h0000 || wr_count !== 16'h0000) begin
      miscompares++; $display("FAIL reset_counts: rd=%h wr=%h expected 0000/0000", rd_count, wr_count);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_turnaround();
    addr = 18'h00010; dq_drv = 16'hA5A5; we_n = 1'b0; tb_oe = 1'b1;
    tick();
    we_n = 1'b1; tb_oe = 1'b0;
    #1;
    vectors++;
    if (SRAM_DQ !== RELEASED) begin
      miscompares++; $display("FAIL turnaround: DQ=%h expected released", SRAM_DQ);
    end
    tick();
    repeat (READ_LAT) tick();
    vectors++;
    if (SRAM_DQ !== 16'hA5A5) begin
      miscompares++; $display("FAIL first_read: DQ=%h expected a5a5", SRAM_DQ);
    end
    tick();
  endtask

  task automatic test_alias();
    addr = 18'h00003; dq_drv = 16'h1234; we_n = 1'b0; tb_oe = 1'b1;
    tick();
    addr = 18'h10003; we_n = 1'b1; tb_oe = 1'b0;
    tick();
    repeat (READ_LAT) tick();
    vectors++;
    if (SRAM_DQ !== 16'h1234) begin
      miscompares++; $display("FAIL alias_read: DQ=%h expected 1234", SRAM_DQ);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    we_n = 1'b0; tb_oe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 18'(i); dq_drv = 16'(i);
      tick();
    end
    we_n = 1'b1; tb_oe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 18'(i);
      tick();
    end
    repeat (READ_LAT + 1) tick();
    vectors++;
    if (rd_count !== want(exp_rd) || wr_count !== want(exp_wr)) begin
      miscompares++;
      $display("FAIL b2b_counts: rd=%h wr=%h expected %h/%h", rd_count, wr_count, want(exp_rd), want(exp_wr));
    end
  endtask

  task automatic test_raw_invalidate();
    addr = 18'h00005; dq_drv = 16'h0001; we_n = 1'b0; tb_oe = 1'b1;
    tick();
    we_n = 1'b1; tb_oe = 1'b0;
    tick();
    dq_drv = 16'h0BEE; we_n = 1'b0; tb_oe = 1'b1;
    tick();
    we_n = 1'b1; tb_oe = 1'b0;
    tick();
    repeat (READ_LAT) tick();
    vectors++;
    if (SRAM_DQ !== 16'h0BEE) begin
      miscompares++; $display("FAIL raw_read: DQ=%h expected 0bee", SRAM_DQ);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    addr = 18'h00010; we_n = 1'b1; tb_oe = 1'b0;
    repeat (2) tick();
    #1;
    rst = 1'b0;
    sb.delete(); exp_rd = 0; exp_wr = 0;
    #1;
    vectors++;
    if (SRAM_DQ !== RELEASED) begin
      miscompares++; $display("FAIL reset_inflight_dq: DQ=%h expected released", SRAM_DQ);
    end
    vectors++;
    if (rd_count !== 16'h0000 || wr_count !== 16'h0000) begin
      miscompares++; $display("FAIL reset_inflight_counts: rd=%h wr=%h expected 0000/0000", rd_count, wr_count);
    end
    dq_drv = 16'h5A5A; we_n = 1'b0; tb_oe = 1'b1;
    repeat (2) tick();
    we_n = 1'b1; tb_oe = 1'b0; rst = 1'b1;
    tick();
    repeat (READ_LAT) tick();
    vectors++;
    if (SRAM_DQ !== 16'hA5A5) begin
      miscompares++; $display("FAIL write_blocked_in_reset: DQ=%h expected a5a5", SRAM_DQ);
    end
    tick();
    vectors++;
    if (rd_count !== want(exp_rd)) begin
      miscompares++; $display("FAIL post_reset_rd_count: rd=%h expected %h", rd_count, want(exp_rd));
    end
  endtask

  task automatic test_counters();
    addr = 18'h00020; we_n = 1'b0; tb_oe = 1'b1;
    for (int i = 0; i < N_WR; i++) begin
      dq_drv = 16'(i);
      tick();
    end
    vectors++;
    if (wr_count !== want(exp_wr)) begin
      miscompares++; $display("FAIL wr_count_long: wr=%h expected %h", wr_count, want(exp_wr));
    end
    dq_drv = 16'h0F0F;
    tick();
    vectors++;
    if (wr_count !== want(exp_wr)) begin
      miscompares++; $display("FAIL wr_count_hold: wr=%h expected %h", wr_count, want(exp_wr));
    end
    we_n = 1'b1; tb_oe = 1'b0;
    repeat (READ_LAT + 3) tick();
    vectors++;
    if (rd_count !== want(exp_rd)) begin
      miscompares++; $display("FAIL rd_count_final: rd=%h expected %h", rd_count, want(exp_rd));
    end
  endtask

  initial begin
    test_reset();
    test_write_turnaround();
    test_alias();
    test_back_to_back();
    test_raw_invalidate();
    test_reset_inflight();
    test_counters();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
